credit_pool_ctrl: RTL and testbench
===================================

Name: credit_pool_ctrl

Overview:
- Token-bucket credit pool shared by NUM_REQ requesters. Used for rate limiting and for sharing outstanding-transaction budgets.
- Periodically refills a credit level by a configured amount, saturating at a configured capacity.
- Grants requests round-robin when the requested amount fits in the current level.
- Sequences a single delta_counter instance that holds the level; at most one net up or down delta is applied per cycle.

Parameters:
- WIDTH, 8, width of credit level, capacity, refill and request amounts.
- NUM_REQ, 4, number of requesters (>=1).
- PERIOD_W, 16, width of the refill period counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear: level, timer and round-robin pointer go to 0.
- cfg_en_i  in  1  enables refill and grants.
- cfg_load_i  in  1  single-cycle pulse: level := cfg_capacity_i.
- cfg_capacity_i  in  WIDTH  maximum level.
- cfg_refill_i  in  WIDTH  credits added per refill tick.
- cfg_period_i  in  PERIOD_W  cycles between refill ticks; 0 is treated as 1.
- req_valid_i  in  NUM_REQ  request valid per requester.
- req_amount_i  in  NUM_REQ x WIDTH  credits requested per requester.
- req_ready_o  out  NUM_REQ  grant; at most one bit is set (one-hot or zero).
- level_o  out  WIDTH  current credit level.
- empty_o  out  1  level_o == 0.
- full_o  out  1  level_o >= cfg_capacity_i.

Behaviour:
- Reset: level 0, timer 0, rr pointer 0. Therefore req_ready_o = 0, level_o = 0, empty_o = 1, full_o = (cfg_capacity_i == 0).
- Update priority per cycle: clear_i > cfg_load_i > normal operation. During a clear or load cycle, req_ready_o = 0 and no refill is applied.
- Timer:
  - Counts while cfg_en_i = 1; held at 0 when cfg_en_i = 0 or clear_i = 1.
  - tick = 1 when timer == max(cfg_period_i, 1) - 1; the timer then wraps to 0.
  - With a period of 0 or 1, tick occurs every enabled cycle.
- Arbitration:
  - Combinational. Only active when cfg_en_i = 1 and there is no clear/load.
  - Candidate = first index with req_valid_i set, searching upward from the rr pointer with wrap.
  - req_ready_o[candidate] = 1 iff req_amount_i[candidate] <= level_o, using the registered level before this cycle's refill.
  - No skipping: if the candidate does not fit, no requester is granted this cycle (avoids starvation of large requests).
  - Transfer = valid & ready. On a transfer, the rr pointer becomes candidate + 1 (mod NUM_REQ); otherwise it holds.
  - Ready may depend on valid. A requester must keep amount stable while valid and not ready.
  - Amount 0 is granted whenever it is the candidate; the level is unchanged.
- Net update, computed in WIDTH+1 bits:
  - cons = transfer ? amount : 0.
  - room = cfg_capacity_i > (level - cons) ? cfg_capacity_i - (level - cons) : 0.
  - ref = tick ? min(cfg_refill_i, room) : 0.
  - If ref >= cons: counter en = (ref != cons), up, delta = ref - cons.
  - Else: down, delta = cons - ref.
- Invariants:
  - Level never exceeds max(capacity, level at capacity change) and never underflows.
  - The counter's overflow output is unused; an assertion requires it to stay 0.
- Capacity lowered below the current level: no refill until the level drops below the new capacity; full_o = 1 meanwhile.
- cfg_load_i applies cfg_capacity_i; the timer and rr pointer are unaffected.
- Latency:
  - Grant is the same cycle the candidate fits.
  - level_o reflects a consumption or refill one cycle later.
- A request amount greater than cfg_capacity_i is illegal: it can block the pool forever. An assertion flags valid with amount > capacity.
- Reset asserted mid-operation: all state returns asynchronously to reset values; in-flight grants are dropped.

Decomposition:
- No shared-package typedefs are needed; level and amount widths derive from WIDTH.
- rr pointer width is $clog2(NUM_REQ), minimum 1, via the codebase's index-width helper in cf_math_pkg.
- Sub-modules:
  - delta_counter #(.WIDTH(WIDTH), .STICKY_OVERFLOW(0)) for the level.
  - clear_i maps to its clear_i, cfg_load_i to load_i with d_i = cfg_capacity_i, and clr_i is tied to 0.
- Round-robin candidate selection stays inline; it is too small to justify a sub-module.

Test Plan:
- Reset, capacity=10, load, period=4, refill=3, no requests -> level 10 immediately after load; ticks clamp, level stays 10; full_o=1.
- Level 10, req0 amount=4 held valid -> grant cycles 1,2; level 6 then 2; cycle 3 not ready (4>2); granted after refill raises level to 5.
- req0..req3 all valid, amount=1, level 10, refill off (period large) -> grants in order 0,1,2,3,0; exactly one ready bit per cycle.
- Level 5, capacity 10, tick and transfer of 4 in same cycle, refill 6 -> ref = min(6, 10-1) = 6, up delta 2, level 7 next cycle.
- req1 amount=8, req2 amount=1, pointer at 1, level 3 -> no grant to either (no skipping) until level >= 8; then req1, then req2.
- clear_i asserted during active grants -> ready 0 that cycle; next cycle level 0, empty_o=1, pointer 0; rst_ni pulse mid-run gives the same result asynchronously.

Source files
------------

// File: rtl/cf_math_pkg.sv
`default_nettype none
// ============================================================================
// cf_math_pkg: shared arithmetic helpers for index and counter sizing.
// Rev 1.0
// ============================================================================
package cf_math_pkg;

  // Width of an index into num_idx entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? $clog2(num_idx) : 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delta_counter.sv
`default_nettype none
// ============================================================================
// delta_counter: up/down counter stepping by a variable delta, with overflow.
// Rev 1.0
// ============================================================================
module delta_counter #(
  parameter int unsigned WIDTH           = 4,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  // One guard bit above the visible count captures wrap in either direction.
  logic [WIDTH:0] counter_q, counter_d;

  always_comb begin
    counter_d = counter_q;
    if (clear_i) begin
      counter_d = '0;
    end else if (load_i) begin
      counter_d = {1'b0, d_i};
    end else if (en_i) begin
      counter_d = down_i ? (counter_q - {1'b0, delta_i}) : (counter_q + {1'b0, delta_i});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign q_o = counter_q[WIDTH-1:0];

  generate
    if (STICKY_OVERFLOW) begin : g_sticky
      logic overflow_q, overflow_d;

      always_comb begin
        overflow_d = overflow_q;
        if (clear_i || load_i || clr_i) begin
          overflow_d = 1'b0;
        end else if (counter_d[WIDTH]) begin
          overflow_d = 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          overflow_q <= 1'b0;
        end else begin
          overflow_q <= overflow_d;
        end
      end

      assign overflow_o = overflow_q;
    end else begin : g_plain
      logic unused_clr;
      assign unused_clr = clr_i;
      assign overflow_o = counter_q[WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/credit_pool_ctrl.sv
`default_nettype none
// ============================================================================
// credit_pool_ctrl: token-bucket credit pool, periodic refill, round-robin grants.
// Rev 1.0
// ============================================================================
module credit_pool_ctrl
  import cf_math_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          cfg_en_i,
  input  logic                          cfg_load_i,
  input  logic [WIDTH-1:0]              cfg_capacity_i,
  input  logic [WIDTH-1:0]              cfg_refill_i,
  input  logic [PERIOD_W-1:0]           cfg_period_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_amount_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WIDTH-1:0]              level_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);

  logic [PERIOD_W-1:0] timer_q, timer_d, period_eff;
  logic [PTR_W-1:0]    rr_q, rr_d, cand;
  logic                cand_found, active, period_hit, refill_tick, transfer;
  logic [WIDTH-1:0]    level, cand_amount;
  logic [WIDTH:0]      cons, rem, room, refill_amt, delta_full;
  logic                cnt_en, cnt_down, cnt_overflow;

  assign active      = cfg_en_i & ~clear_i & ~cfg_load_i;
  assign period_eff  = (cfg_period_i == '0) ? PERIOD_W'(1) : cfg_period_i;
  assign period_hit  = (timer_q == (period_eff - PERIOD_W'(1)));
  assign refill_tick = active & period_hit;

  always_comb begin
    timer_d = timer_q + PERIOD_W'(1);
    if (clear_i || !cfg_en_i || period_hit) begin
      timer_d = '0;
    end
  end

  always_comb begin
    int unsigned    idx;
    logic [PTR_W-1:0] idx_p;
    idx        = 0;
    idx_p      = '0;
    cand       = rr_q;
    cand_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_q) + k) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!cand_found && req_valid_i[idx_p]) begin
        cand       = idx_p;
        cand_found = 1'b1;
      end
    end
  end

  assign cand_amount = req_amount_i[cand];

  // Only the candidate may be granted; a non-fitting candidate blocks everyone.
  always_comb begin
    req_ready_o = '0;
    if (active && cand_found && (cand_amount <= level)) begin
      req_ready_o[cand] = 1'b1;
    end
  end

  assign transfer = |(req_ready_o & req_valid_i);

  always_comb begin
    rr_d = rr_q;
    if (clear_i) begin
      rr_d = '0;
    end else if (transfer) begin
      rr_d = (cand == PTR_W'(NUM_REQ - 1)) ? '0 : (cand + PTR_W'(1));
    end
  end

  always_comb begin
    cons       = transfer ? {1'b0, cand_amount} : '0;
    rem        = {1'b0, level} - cons;
    room       = ({1'b0, cfg_capacity_i} > rem) ? ({1'b0, cfg_capacity_i} - rem) : '0;
    refill_amt = '0;
    cnt_en     = 1'b0;
    cnt_down   = 1'b0;
    delta_full = '0;
    if (refill_tick) begin
      refill_amt = ({1'b0, cfg_refill_i} < room) ? {1'b0, cfg_refill_i} : room;
    end
    // Consumption and refill collapse into a single signed step.
    if (refill_amt >= cons) begin
      cnt_en     = active && (refill_amt != cons);
      delta_full = refill_amt - cons;
    end else begin
      cnt_en     = active;
      cnt_down   = 1'b1;
      delta_full = cons - refill_amt;
    end
  end

  delta_counter #(
    .WIDTH           (WIDTH),
    .STICKY_OVERFLOW (1'b0)
  ) u_level_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .en_i       (cnt_en),
    .load_i     (cfg_load_i),
    .down_i     (cnt_down),
    .delta_i    (delta_full[WIDTH-1:0]),
    .d_i        (cfg_capacity_i),
    .clr_i      (1'b0),
    .q_o        (level),
    .overflow_o (cnt_overflow)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      rr_q    <= '0;
    end else begin
      timer_q <= timer_d;
      rr_q    <= rr_d;
    end
  end

  assign level_o = level;
  assign empty_o = (level == '0);
  assign full_o  = (level >= cfg_capacity_i);

`ifndef SYNTHESIS
  logic [NUM_REQ-1:0] amount_illegal;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_amt_chk
    assign amount_illegal[r] = req_valid_i[r] && (req_amount_i[r] > cfg_capacity_i);
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !cnt_overflow && !delta_full[WIDTH])
    else $error("credit_pool_ctrl: level counter overflow");

  a_amount_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
      amount_illegal == '0)
    else $error("credit_pool_ctrl: request amount exceeds capacity");
`endif

endmodule
`default_nettype wire

// File: tb/tb_credit_pool_ctrl.sv
`default_nettype none
// ============================================================================
// tb_credit_pool_ctrl: vector table, directed corner sequences, random vs model.
// Rev 1.0
// ============================================================================
module tb_credit_pool_ctrl;

  localparam int WIDTH    = 8;
  localparam int NUM_REQ  = 4;
  localparam int PERIOD_W = 16;

  logic                          clk_i = 1'b0;
  logic                          rst_ni = 1'b0;
  logic                          clear_i = 1'b0;
  logic                          cfg_en_i = 1'b0;
  logic                          cfg_load_i = 1'b0;
  logic [WIDTH-1:0]              cfg_capacity_i = '0;
  logic [WIDTH-1:0]              cfg_refill_i = '0;
  logic [PERIOD_W-1:0]           cfg_period_i = '0;
  logic [NUM_REQ-1:0]            req_valid_i = '0;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_amount_i = '0;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [WIDTH-1:0]              level_o;
  logic                          empty_o;
  logic                          full_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pool level, enabled-cycle timer, next preferred requester.
  int m_level = 0;
  int m_timer = 0;
  int m_rr    = 0;

  credit_pool_ctrl #(
    .WIDTH    (WIDTH),
    .NUM_REQ  (NUM_REQ),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_load_i     (cfg_load_i),
    .cfg_capacity_i (cfg_capacity_i),
    .cfg_refill_i   (cfg_refill_i),
    .cfg_period_i   (cfg_period_i),
    .req_valid_i    (req_valid_i),
    .req_amount_i   (req_amount_i),
    .req_ready_o    (req_ready_o),
    .level_o        (level_o),
    .empty_o        (empty_o),
    .full_o         (full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       clr;
    logic       en;
    logic       ld;
    logic [3:0] valid;
    logic [7:0] amt;
    logic [3:0] rdy;
    logic [7:0] lvl;
    logic       emp;
    logic       full;
  } vec_t;

  function automatic vec_t mk(input logic clr, input logic en, input logic ld,
                              input logic [3:0] valid, input logic [7:0] amt,
                              input logic [3:0] rdy, input logic [7:0] lvl,
                              input logic emp, input logic full);
    vec_t v;
    v.clr = clr; v.en = en; v.ld = ld; v.valid = valid; v.amt = amt;
    v.rdy = rdy; v.lvl = lvl; v.emp = emp; v.full = full;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The candidate is the first valid requester at or after m_rr; it alone may win.
  function automatic logic [NUM_REQ-1:0] model_ready();
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (cfg_en_i && !clear_i && !cfg_load_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % NUM_REQ;
        if (req_valid_i[idx]) begin
          if (int'(req_amount_i[idx]) <= m_level) r[idx] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step();
    logic [NUM_REQ-1:0] r;
    int  p, cons, g, room, add;
    bit  tick;
    r    = model_ready();
    p    = (cfg_period_i == 0) ? 1 : int'(cfg_period_i);
    tick = cfg_en_i && (m_timer == p - 1);
    cons = 0;
    g    = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[k]) begin
        cons = int'(req_amount_i[k]);
        g    = k;
      end
    end
    if (clear_i) begin
      m_level = 0; m_timer = 0; m_rr = 0;
      return;
    end
    m_timer = !cfg_en_i ? 0 : (tick ? 0 : (m_timer + 1) % 65536);
    if (cfg_load_i) begin
      m_level = int'(cfg_capacity_i);
      return;
    end
    m_level = m_level - cons;
    if (tick) begin
      room = int'(cfg_capacity_i) - m_level;
      if (room < 0) room = 0;
      add  = (int'(cfg_refill_i) < room) ? int'(cfg_refill_i) : room;
      m_level = m_level + add;
    end
    if (g >= 0) m_rr = (g + 1) % NUM_REQ;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, int'(req_ready_o), int'(model_ready()));
    chk({tag, ".level"}, int'(level_o), m_level);
    chk({tag, ".empty"}, int'(empty_o), int'(m_level == 0));
    chk({tag, ".full"},  int'(full_o),  int'(m_level >= int'(cfg_capacity_i)));
  endtask

  task automatic clock_edge();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic set_amounts(input int a0, input int a1, input int a2, input int a3);
    req_amount_i[0] = WIDTH'(a0);
    req_amount_i[1] = WIDTH'(a1);
    req_amount_i[2] = WIDTH'(a2);
    req_amount_i[3] = WIDTH'(a3);
  endtask

  vec_t tbl [13];

  initial begin
    // capacity 10, refill 3 every 4 enabled cycles, one requester asking for 4
    tbl[0]  = mk(0, 0, 0, 4'h0, 8'd0, 4'h0, 8'd0,  1, 0);
    tbl[1]  = mk(0, 1, 1, 4'h0, 8'd0, 4'h0, 8'd0,  1, 0);
    tbl[2]  = mk(0, 1, 0, 4'h0, 8'd0, 4'h0, 8'd10, 0, 1);
    tbl[3]  = mk(0, 1, 0, 4'h0, 8'd0, 4'h0, 8'd10, 0, 1);
    tbl[4]  = mk(0, 1, 0, 4'h0, 8'd0, 4'h0, 8'd10, 0, 1);
    tbl[5]  = mk(0, 1, 0, 4'h1, 8'd4, 4'h1, 8'd10, 0, 1);
    tbl[6]  = mk(0, 1, 0, 4'h1, 8'd4, 4'h1, 8'd6,  0, 0);
    tbl[7]  = mk(0, 1, 0, 4'h1, 8'd4, 4'h0, 8'd2,  0, 0);
    tbl[8]  = mk(0, 1, 0, 4'h1, 8'd4, 4'h0, 8'd2,  0, 0);
    tbl[9]  = mk(0, 1, 0, 4'h1, 8'd4, 4'h1, 8'd5,  0, 0);
    tbl[10] = mk(0, 1, 0, 4'h1, 8'd4, 4'h0, 8'd1,  0, 0);
    tbl[11] = mk(1, 1, 0, 4'h1, 8'd4, 4'h0, 8'd1,  0, 0);
    tbl[12] = mk(0, 1, 0, 4'h0, 8'd0, 4'h0, 8'd0,  1, 0);

    cfg_capacity_i = 8'd10;
    cfg_refill_i   = 8'd3;
    cfg_period_i   = 16'd4;
    #12 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (tbl[i]) begin
      clear_i     = tbl[i].clr;
      cfg_en_i    = tbl[i].en;
      cfg_load_i  = tbl[i].ld;
      req_valid_i = tbl[i].valid;
      set_amounts(int'(tbl[i].amt), 1, 1, 1);
      #2;
      chk($sformatf("tbl%0d.ready", i), int'(req_ready_o), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d.level", i), int'(level_o),     int'(tbl[i].lvl));
      chk($sformatf("tbl%0d.empty", i), int'(empty_o),     int'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i),  int'(full_o),      int'(tbl[i].full));
      clock_edge();
    end

    // Round robin over four equal small requests, no refill in reach.
    cfg_period_i = 16'd1000;
    cfg_load_i   = 1'b1;
    req_valid_i  = '0;
    #2; check_model("rr_load"); clock_edge();
    cfg_load_i  = 1'b0;
    req_valid_i = 4'hF;
    set_amounts(1, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("rr%0d.grant", k), int'(req_ready_o), 1 << (k % 4));
      chk($sformatf("rr%0d.onehot", k), $countones(req_ready_o), 1);
      check_model($sformatf("rr%0d", k));
      clock_edge();
    end

    // Refill tick coinciding with a transfer: 5 - 4 + min(6, 9) = 7.
    cfg_en_i = 1'b0; req_valid_i = '0; cfg_capacity_i = 8'd5; cfg_load_i = 1'b1;
    #2; check_model("tt_load"); clock_edge();
    cfg_load_i = 1'b0; cfg_capacity_i = 8'd10; cfg_refill_i = 8'd6; cfg_period_i = 16'd1;
    cfg_en_i = 1'b1; req_valid_i = 4'h1; set_amounts(4, 0, 0, 0);
    #2;
    chk("tt.grant", int'(req_ready_o), 1);
    check_model("tt"); clock_edge();
    cfg_en_i = 1'b0; req_valid_i = '0;
    #2;
    chk("tt.level", int'(level_o), 7);
    check_model("tt_after"); clock_edge();

    // Large candidate blocks the small one behind it until refills cover it.
    cfg_capacity_i = 8'd3; cfg_load_i = 1'b1;
    #2; check_model("ns_load"); clock_edge();
    cfg_load_i = 1'b0; cfg_capacity_i = 8'd10; cfg_refill_i = 8'd2; cfg_period_i = 16'd2;
    cfg_en_i = 1'b1; req_valid_i = 4'b0110; set_amounts(0, 8, 1, 0);
    for (int c = 0; c < 8; c++) begin
      #2;
      if (c < 6)       chk($sformatf("ns%0d.blocked", c), int'(req_ready_o), 0);
      else if (c == 6) chk("ns6.big_first", int'(req_ready_o), 2);
      else             chk("ns7.small_next", int'(req_ready_o), 4);
      check_model($sformatf("ns%0d", c));
      clock_edge();
    end

    // Clear during active grants, then asynchronous reset mid-run.
    req_valid_i = '0; cfg_load_i = 1'b1; cfg_period_i = 16'd3; cfg_refill_i = 8'd1;
    #2; check_model("cl_load"); clock_edge();
    cfg_load_i = 1'b0; req_valid_i = 4'hF; set_amounts(2, 2, 2, 2);
    for (int c = 0; c < 3; c++) begin
      #2; check_model($sformatf("cl_run%0d", c)); clock_edge();
    end
    clear_i = 1'b1;
    #2;
    chk("cl.ready_during_clear", int'(req_ready_o), 0);
    check_model("cl"); clock_edge();
    clear_i = 1'b0; set_amounts(0, 0, 0, 0);
    #2;
    chk("cl.level", int'(level_o), 0);
    chk("cl.empty", int'(empty_o), 1);
    chk("cl.ptr_zero", int'(req_ready_o), 1);
    check_model("cl_after"); clock_edge();
    set_amounts(2, 2, 2, 2); cfg_load_i = 1'b1;
    #2; check_model("rs_load"); clock_edge();
    cfg_load_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2; check_model($sformatf("rs_run%0d", c)); clock_edge();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rs.level", int'(level_o), 0);
    chk("rs.ready", int'(req_ready_o), 0);
    chk("rs.empty", int'(empty_o), 1);
    m_level = 0; m_timer = 0; m_rr = 0;
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    #1; check_model("rs_after"); clock_edge();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      clear_i    = ($urandom_range(0, 63) == 0);
      cfg_load_i = ($urandom_range(0, 31) == 0);
      cfg_en_i   = ($urandom_range(0, 9) != 0);
      if (clear_i) begin
        cfg_period_i = PERIOD_W'($urandom_range(0, 5));
        cfg_refill_i = WIDTH'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 39) == 0) cfg_capacity_i = WIDTH'($urandom_range(0, 40));
      req_valid_i = NUM_REQ'($urandom);
      for (int k = 0; k < NUM_REQ; k++) begin
        req_amount_i[k] = WIDTH'($urandom_range(0, int'(cfg_capacity_i)));
      end
      #2;
      check_model($sformatf("rnd%0d", n));
      clock_edge();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
